spi_piso_tx: RTL and testbench
==============================

# spi_piso_tx

SPI transmit engine: parallel-in, serial-out counterpart of the SPI receive shifter. Accepts a `NUM_BITS` word over a valid/ready handshake and serialises it MSB first on `mosi`. It generates `sclk` (SPI mode 0, CPOL=0/CPHA=0) and `csN` for one frame per word. It sits between the register/control logic and the SPI pins, so the far end's serial-in shifter rebuilds the word in its original bit order.

## Interface
- `NUM_BITS`, default 12: bits per SPI word; legal range ≥ 2.
- `CLK_DIV`, default 4: `clk` cycles per half `sclk` period; legal range ≥ 1.
- `clk` input 1: single system clock; all logic on posedge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `txData` input `NUM_BITS`: word to send; sampled only on handshake.
- `txValid` input 1: `txData` valid.
- `txReady` output 1: engine idle, can accept a word.
- `sclk` output 1: SPI clock, idles low.
- `mosi` output 1: serial data, MSB first.
- `csN` output 1: chip select, active-low.
- `done` output 1: one-cycle pulse at frame end.

## Operation
- All outputs are registered.
- Reset values: `sclk`=0, `csN`=1, `mosi`=0, `txReady`=1, `done`=0. State returns to IDLE and the shift register and counters clear.
- States: IDLE → SETUP → HIGH ↔ LOW → HOLD → IDLE.
- **IDLE**
  - `txReady`=1, `csN`=1, `sclk`=0, `mosi`=0.
  - Handshake = `txValid && txReady` at a posedge.
  - On handshake: load `txData` into the shift register and move to SETUP.
- **SETUP** (`CLK_DIV` cycles)
  - `csN`=0, `sclk`=0, `mosi`=`txData[NUM_BITS-1]`.
- **HIGH** (`CLK_DIV` cycles)
  - `sclk`=1; `mosi` is stable. The receiver samples on this rising edge.
  - If the bit count is below `NUM_BITS`, go to LOW. Otherwise go to HOLD.
- **LOW** (`CLK_DIV` cycles)
  - `sclk`=0.
  - Shift left by one on entry, so `mosi` presents the next bit.
  - Then go to HIGH.
- **HOLD** (`CLK_DIV` cycles)
  - `sclk`=0, `csN`=0, `mosi` holds the LSB.
  - Then go to IDLE.
- **IDLE entry cycle**: `csN`=1, `txReady`=1, `done`=1 for exactly this cycle.
- Bit counter width is `$clog2(NUM_BITS+1)`. Half-period counter width is `$clog2(CLK_DIV)`, minimum 1 bit. The half-period counter wraps to 0 on each state change.
- `txData`/`txValid` changes after the handshake have no effect until the next IDLE.
- `txReady` is 0 from SETUP through HOLD. `txValid` held high during a frame is not consumed.
- Reset mid-frame: outputs go to their reset values immediately (`csN`=1 asynchronously). The word is discarded and `done` is not pulsed.

## Timing
- Handshake at posedge T. At T+1: `csN`=0, `mosi`=MSB, `txReady`=0.
- First `sclk` rising edge at T+1+`CLK_DIV`.
- `sclk` period = 2·`CLK_DIV` clk cycles, 50% duty cycle.
- `mosi` changes only on `sclk` falling edges (LOW entry). It is stable ≥ `CLK_DIV` cycles on each side of every rising edge.
- `csN` low duration = `CLK_DIV`·(2·`NUM_BITS`+1) cycles. Defaults: 4·25 = 100 cycles.
- `done` and `csN`=1 are asserted at T+1+`CLK_DIV`·(2·`NUM_BITS`+1).
- Back-to-back words: a handshake in the first IDLE cycle (the same cycle as `done`) is allowed. `csN` is then high for exactly 1 cycle between frames.
- Rising `sclk` edges per frame = `NUM_BITS`. No `sclk` edges occur while `csN`=1.

## Test plan
- Reset: assert `rst_n`=0 mid-frame (defaults, after 5 `sclk` edges) → same cycle `csN`=1, `sclk`=0, `mosi`=0. After release: `txReady`=1, no `done` pulse.
- Single word: `txData`=12'hA5C, `CLK_DIV`=4 → `mosi` sampled on 12 `sclk` rising edges = 1010_0101_1100. `csN` low for 100 cycles, one `done` pulse, `txReady`=1 after it.
- Minimum divider: `CLK_DIV`=1, `NUM_BITS`=2, `txData`=2'b10 → `csN` low 5 cycles. `sclk` pattern 0,1,0,1,0. Bits sampled 1 then 0.
- Back-to-back: `txValid` held high with 12'hFFF then 12'h001 → second handshake on the `done` cycle, `csN` high exactly 1 cycle, second frame samples 000000000001.
- Data stability: change `txData` every cycle during a frame loaded with 12'h800 → serial output is still 1000_0000_0000, and `txReady` stays 0 until `done`.
- Receiver loopback: drive a 12-bit serial-in shifter with `dataIn`=`mosi`, `enable` on `sclk` rising edges, random words ×1000 → parallel output equals `txData` at each `done`.

Source files
------------

// File: rtl/spi_piso_tx_if.sv
// ----------------------------------------------------------------------------
// spi_piso_tx_if
//   Bundles the word handshake and the SPI pin signals of the SPI transmit
//   engine so they can be passed as a single port.
//
//   Signals:
//     txData  [NUM_BITS] word to send, sampled only on handshake
//     txValid            txData valid
//     txReady            engine idle, can accept a word
//     sclk               SPI clock, idles low (mode 0)
//     mosi               serial data, MSB first
//     csN                chip select, active-low
//     done               one-cycle pulse at frame end
//
//   Modports:
//     master : the word producer (drives txData/txValid, observes the rest)
//     slave  : the transmit engine
// ----------------------------------------------------------------------------
interface spi_piso_tx_if #(
    parameter int NUM_BITS = 12
);
    logic [NUM_BITS-1:0] txData;
    logic                txValid;
    logic                txReady;
    logic                sclk;
    logic                mosi;
    logic                csN;
    logic                done;

    modport master (
        output txData,
        output txValid,
        input  txReady,
        input  sclk,
        input  mosi,
        input  csN,
        input  done
    );

    modport slave (
        input  txData,
        input  txValid,
        output txReady,
        output sclk,
        output mosi,
        output csN,
        output done
    );
endinterface

// File: rtl/spi_piso_tx.sv
// ----------------------------------------------------------------------------
// spi_piso_tx
//   SPI transmit engine (mode 0, CPOL=0/CPHA=0). Accepts a NUM_BITS word over
//   a valid/ready handshake and shifts it out MSB first on mosi, generating
//   sclk and csN for one frame per word. All outputs are registered.
//
//   Frame: IDLE -> SETUP -> (HIGH <-> LOW) -> HOLD -> IDLE, every non-IDLE
//   state lasting CLK_DIV clk cycles. csN stays low for
//   CLK_DIV*(2*NUM_BITS+1) cycles; done pulses on the IDLE entry cycle.
//
//   Parameters:
//     NUM_BITS  bits per SPI word (>= 2)
//     CLK_DIV   clk cycles per half sclk period (>= 1)
//
//   Ports:
//     clk    system clock, posedge
//     rst_n  asynchronous active-low reset
//     bus    spi_piso_tx_if.slave (txData/txValid in; txReady, sclk, mosi,
//            csN, done out)
// ----------------------------------------------------------------------------
module spi_piso_tx #(
    parameter int NUM_BITS = 12,
    parameter int CLK_DIV  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_piso_tx_if.slave  bus
);

    localparam int BIT_W = $clog2(NUM_BITS + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_ALL  = BIT_W'(NUM_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW,
        ST_HOLD
    } state_e;

    state_e              state_q,  state_d;
    logic [DIV_W-1:0]    div_q,    div_d;
    logic [BIT_W-1:0]    bit_q,    bit_d;
    logic [NUM_BITS-1:0] shreg_q,  shreg_d;
    logic                sclk_q,   sclk_d;
    logic                mosi_q,   mosi_d;
    logic                csn_q,    csn_d;
    logic                ready_q,  ready_d;
    logic                done_q,   done_d;

    // Last cycle of the current half period.
    logic half_end;
    assign half_end = (div_q == DIV_LAST);

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        div_d   = div_q + DIV_W'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        csn_d   = csn_q;
        ready_d = ready_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (bus.txValid && ready_q) begin
                    state_d = ST_SETUP;
                    shreg_d = bus.txData;
                    mosi_d  = bus.txData[NUM_BITS-1];
                    csn_d   = 1'b0;
                    ready_d = 1'b0;
                    bit_d   = '0;
                end
            end

            ST_SETUP: begin
                if (half_end) begin
                    state_d = ST_HIGH;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    bit_d   = bit_q + BIT_W'(1);
                end
            end

            ST_HIGH: begin
                if (half_end) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q < BIT_ALL) begin
                        // Falling edge: present the next bit for the receiver.
                        state_d = ST_LOW;
                        shreg_d = {shreg_q[NUM_BITS-2:0], 1'b0};
                        mosi_d  = shreg_q[NUM_BITS-2];
                    end else begin
                        // mosi keeps the LSB through HOLD.
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_LOW: begin
                if (half_end) begin
                    state_d = ST_HIGH;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    bit_d   = bit_q + BIT_W'(1);
                end
            end

            ST_HOLD: begin
                if (half_end) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    csn_d   = 1'b1;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    mosi_d  = 1'b0;
                    bit_d   = '0;
                    shreg_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                bit_d   = '0;
                shreg_d = '0;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                csn_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register. Reset drives csN high and sclk/mosi low immediately,
    // discarding any word in flight without a done pulse.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csn_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csn_q   <= csn_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign bus.txReady = ready_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.csN     = csn_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_piso_tx.sv
// ----------------------------------------------------------------------------
// tb_spi_piso_tx
//   Directed bench for spi_piso_tx. Three instances:
//     u_a : NUM_BITS=12, CLK_DIV=4 (defaults)
//     u_b : NUM_BITS=2,  CLK_DIV=1 (minimum divider)
//     u_c : NUM_BITS=12, CLK_DIV=1 (fast loopback against a serial-in shifter)
//   Outputs are sampled on the falling clk edge; inputs change there too.
// ----------------------------------------------------------------------------
module tb_spi_piso_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    spi_piso_tx_if #(.NUM_BITS(12)) bus_a ();
    spi_piso_tx_if #(.NUM_BITS(2))  bus_b ();
    spi_piso_tx_if #(.NUM_BITS(12)) bus_c ();

    spi_piso_tx #(.NUM_BITS(12), .CLK_DIV(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    spi_piso_tx #(.NUM_BITS(2),  .CLK_DIV(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    spi_piso_tx #(.NUM_BITS(12), .CLK_DIV(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Results of the last run_a() call.
    logic [11:0] wq[$];      // words to send
    logic [11:0] rxq[$];     // words rebuilt from mosi on sclk rising edges
    int          lowq[$];    // csN-low cycles per frame
    int          edgeq[$];   // sclk rising edges per frame
    int          gapq[$];    // csN-high cycles between consecutive frames
    int          first_rise; // csN-low cycle index of the first sclk high
    int          sclk_bad;   // sclk rising edges seen with csN high
    int          ready_bad;  // cycles with txReady high while csN low
    int          done_cnt;

    // Sends the words in wq to u_a with txValid held high across frames, so
    // each following word is taken on the done cycle of the previous one.
    // With scramble set, txData is randomised every cycle of the frame.
    task automatic run_a(input bit scramble);
        int          hs        = 0;
        int          cyc       = 0;
        int          low       = 0;
        int          edges     = 0;
        int          gap       = 0;
        bit          in_gap    = 0;
        bit          prev_csn  = 1;
        bit          prev_sclk = 0;
        logic [11:0] rx        = '0;
        rxq.delete(); lowq.delete(); edgeq.delete(); gapq.delete();
        first_rise = -1; sclk_bad = 0; ready_bad = 0; done_cnt = 0;

        @(negedge clk);
        bus_a.txData  = wq[0];
        bus_a.txValid = 1'b1;
        while (done_cnt < wq.size() && cyc < 400 * wq.size()) begin
            @(negedge clk);
            cyc++;
            if (!bus_a.csN && prev_csn) begin
                hs++;
                if (in_gap) gapq.push_back(gap);
                in_gap = 0;
                if (hs >= wq.size()) bus_a.txValid = 1'b0;
                else                 bus_a.txData  = wq[hs];
            end
            if (scramble && hs > 0 && done_cnt < hs) bus_a.txData = 12'($urandom);
            if (!bus_a.csN) low++;
            if (bus_a.sclk && !prev_sclk) begin
                if (edges == 0 && first_rise < 0) first_rise = low;
                rx = {rx[10:0], bus_a.mosi};
                edges++;
                if (bus_a.csN) sclk_bad++;
            end
            if (bus_a.txReady && !bus_a.csN) ready_bad++;
            if (bus_a.done) begin
                done_cnt++;
                rxq.push_back(rx);
                lowq.push_back(low);
                edgeq.push_back(edges);
                low = 0; edges = 0; rx = '0;
                in_gap = 1; gap = 0;
            end
            if (in_gap && bus_a.csN) gap++;
            prev_csn  = bus_a.csN;
            prev_sclk = bus_a.sclk;
        end
        check("a_frames_done", done_cnt, wq.size());
    endtask

    initial begin
        int          e;
        int          dn;
        int          rises;
        int          low;
        bit          prev;
        logic [7:0]  pat;
        logic [1:0]  rxb;
        logic [11:0] w;
        logic [11:0] rxc;
        bit          got;

        bus_a.txData = '0; bus_a.txValid = 1'b0;
        bus_b.txData = '0; bus_b.txValid = 1'b0;
        bus_c.txData = '0; bus_c.txValid = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_a_ready", bus_a.txReady, 1);
        check("rst_a_csn",   bus_a.csN,     1);
        check("rst_a_sclk",  bus_a.sclk,    0);
        check("rst_a_mosi",  bus_a.mosi,    0);
        check("rst_a_done",  bus_a.done,    0);
        check("rst_b_ready", bus_b.txReady, 1);
        check("rst_c_ready", bus_c.txReady, 1);

        // ---------------- single word 12'hA5C ----------------
        wq = '{12'hA5C};
        run_a(1'b0);
        check("single_word",       rxq.size() > 0 ? rxq[0]  : 12'hxxx, 12'hA5C);
        check("single_csn_low",    lowq.size() > 0 ? lowq[0] : -1, 100);
        check("single_edges",      edgeq.size() > 0 ? edgeq[0] : -1, 12);
        check("single_first_rise", first_rise, 5);
        check("single_sclk_idle",  sclk_bad, 0);
        check("single_ready_busy", ready_bad, 0);
        check("single_done_ready", bus_a.txReady, 1);
        check("single_done_csn",   bus_a.csN, 1);
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.done) dn++;
        end
        check("single_done_once", dn, 0);
        check("single_idle_mosi", bus_a.mosi, 0);

        // ---------------- minimum divider, 2 bits ----------------
        @(negedge clk);
        bus_b.txData  = 2'b10;
        bus_b.txValid = 1'b1;
        pat = '0; rxb = '0; low = 0; prev = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (i == 0) bus_b.txValid = 1'b0;
            if (!bus_b.csN) begin
                low++;
                pat = {pat[6:0], bus_b.sclk};
            end
            if (bus_b.sclk && !prev) rxb = {rxb[0], bus_b.mosi};
            prev = bus_b.sclk;
            if (bus_b.done) got = 1;
        end
        check("min_done",     got, 1);
        check("min_csn_low",  low, 5);
        check("min_sclk_pat", pat, 8'b0000_1010);
        check("min_bits",     rxb, 2'b10);

        // ---------------- back-to-back ----------------
        wq = '{12'hFFF, 12'h001};
        run_a(1'b0);
        check("b2b_word0", rxq.size() > 0 ? rxq[0] : 12'hxxx, 12'hFFF);
        check("b2b_word1", rxq.size() > 1 ? rxq[1] : 12'hxxx, 12'h001);
        check("b2b_gap",   gapq.size() > 0 ? gapq[0] : -1, 1);
        check("b2b_low0",  lowq.size() > 0 ? lowq[0] : -1, 100);
        check("b2b_low1",  lowq.size() > 1 ? lowq[1] : -1, 100);
        check("b2b_sclk_idle", sclk_bad, 0);
        repeat (3) @(negedge clk);
        check("b2b_not_reconsumed", bus_a.csN, 1);

        // ---------------- data stability ----------------
        wq = '{12'h800};
        run_a(1'b1);
        check("stable_word",       rxq.size() > 0 ? rxq[0] : 12'hxxx, 12'h800);
        check("stable_ready_busy", ready_bad, 0);
        check("stable_csn_low",    lowq.size() > 0 ? lowq[0] : -1, 100);

        // ---------------- reset mid-frame ----------------
        @(negedge clk);
        bus_a.txData  = 12'hA5C;
        bus_a.txValid = 1'b1;
        @(negedge clk);
        bus_a.txValid = 1'b0;
        e = 0; prev = 0;
        for (int i = 0; i < 200 && e < 5; i++) begin
            @(negedge clk);
            if (bus_a.sclk && !prev) e++;
            prev = bus_a.sclk;
        end
        check("rst_mid_edges", e, 5);
        check("rst_mid_pre_csn", bus_a.csN, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_csn",  bus_a.csN,  1);
        check("rst_mid_sclk", bus_a.sclk, 0);
        check("rst_mid_mosi", bus_a.mosi, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0; rises = 0; prev = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus_a.done) dn++;
            if (bus_a.sclk && !prev) rises++;
            prev = bus_a.sclk;
        end
        check("rst_mid_no_done", dn, 0);
        check("rst_mid_no_sclk", rises, 0);
        check("rst_mid_ready",   bus_a.txReady, 1);

        // ---------------- receiver loopback ----------------
        for (int n = 0; n < 1000; n++) begin
            w = 12'($urandom);
            @(negedge clk);
            bus_c.txData  = w;
            bus_c.txValid = 1'b1;
            rxc = '0; prev = 0; got = 0;
            for (int i = 0; i < 60 && !got; i++) begin
                @(negedge clk);
                if (i == 0) bus_c.txValid = 1'b0;
                if (bus_c.sclk && !prev) rxc = {rxc[10:0], bus_c.mosi};
                prev = bus_c.sclk;
                if (bus_c.done) got = 1;
            end
            check("loop_done", got, 1);
            check("loop_word", rxc, w);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
